// File: rtl/sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
// sevenseg_scan_driver : time-multiplexed N-digit seven-segment scan driver
//   Optional build macro SEVSEG_LZ_BLANK_EN enables leading-zero blanking.
// Rev 1.0
// ============================================================================
module sevenseg_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GHOST_CYC   = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    GHOST_END = CNT_W'(GHOST_CYC);
  localparam logic [IDX_W-1:0]    IDX_MAX   = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_POL   = {7{ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] AN_POL    = {N_DIGITS{ACTIVE_LOW}};

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] val_q, val_d;
  logic [N_DIGITS-1:0]   dpm_q, dpm_d;
  logic                  hex_q, hex_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  blank;
  logic [6:0]            seg_ah;
  logic [N_DIGITS-1:0]   an_ah;

  function automatic logic [6:0] decode(input logic [3:0] n, input logic hex);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    if (!hex && (n > 4'd9)) begin
      s = 7'b0000000;
    end
    return s;
  endfunction

  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    an_ah  = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib      = val_q[4*i +: 4];
        dp_sel   = dpm_q[i];
        an_ah[i] = (cnt_q >= GHOST_END);
      end
    end

`ifdef SEVSEG_LZ_BLANK_EN
    // A digit is leading-zero if it and every digit above it are zero; digit 0 never blanks.
    blank = (idx_q != '0);
    for (int i = 0; i < N_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx_q) && (val_q[4*i +: 4] != 4'h0)) begin
        blank = 1'b0;
      end
    end
`else
    blank = 1'b0;
`endif

    seg_ah = blank ? 7'b0000000 : decode(nib, hex_q);
    seg_d  = seg_ah ^ SEG_POL;
    dp_d   = dp_sel ^ ACTIVE_LOW;
    an_d   = an_ah ^ AN_POL;

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end

    val_d = load ? value    : val_q;
    dpm_d = load ? dp_in    : dpm_q;
    hex_d = load ? hex_mode : hex_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      val_q <= '0;
      dpm_q <= '0;
      hex_q <= 1'b0;
      seg_q <= SEG_POL;
      dp_q  <= ACTIVE_LOW;
      an_q  <= AN_POL;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      val_q <= val_d;
      dpm_q <= dpm_d;
      hex_q <= hex_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_driver.sv
`default_nettype none
// tb_sevenseg_scan_driver : randomized bench with a slot/digit arithmetic reference model.
module tb_sevenseg_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int GC = 1;
  localparam bit AL = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value;
  logic          load;
  logic          hex_mode;
  logic [3:0]    dp_in;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: cycles since reset plus the last captured display data.
  int          m_t;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_hex;
  logic [6:0]  seg_tbl [16];

  sevenseg_scan_driver #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RD),
    .GHOST_CYC   (GC),
    .ACTIVE_LOW  (AL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .load     (load),
    .hex_mode (hex_mode),
    .dp_in    (dp_in),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t, model cycle %0d)", tag, obs, exp, $time, m_t);
    end
  endtask

  function automatic void model_out(output logic [6:0] s, output logic d, output logic [3:0] a);
    int         slot;
    int         dig;
    logic [3:0] n;
    logic [6:0] sh;
    logic [3:0] ah;
    slot = m_t % RD;
    dig  = (m_t / RD) % N;
    n    = m_val[4*dig +: 4];
    sh   = (m_hex || n < 4'd10) ? seg_tbl[n] : 7'h00;
`ifdef SEVSEG_LZ_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int i = 0; i < N; i++) if (m_val[4*i +: 4] != 4'h0) msd = i;
      if (dig > msd) sh = 7'h00;
    end
`endif
    ah = (slot >= GC) ? 4'(1 << dig) : 4'h0;
    s  = AL ? ~sh : sh;
    d  = AL ? ~m_dp[dig] : m_dp[dig];
    a  = AL ? ~ah : ah;
  endfunction

  // One clock: predict outputs from pre-edge model state, advance model, compare after the edge.
  task automatic tick();
    logic [6:0] es;
    logic       ed;
    logic [3:0] ea;
    if (!rst_n) begin
      es = AL ? 7'h7F : 7'h00;
      ed = AL;
      ea = AL ? 4'hF : 4'h0;
      m_t = 0; m_val = '0; m_dp = '0; m_hex = 1'b0;
    end else begin
      model_out(es, ed, ea);
      if (load) begin
        m_val = value; m_dp = dp_in; m_hex = hex_mode;
      end
      m_t++;
    end
    @(posedge clk);
    #1;
    check_val("seg", {25'd0, seg}, {25'd0, es});
    check_val("dp",  {31'd0, dp},  {31'd0, ed});
    check_val("an",  {28'd0, an},  {28'd0, ea});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      value = 16'($urandom);  // ignored without load
      tick();
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic h, input logic [3:0] d);
    value = v; hex_mode = h; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    seg_tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    m_t = 0; m_val = '0; m_dp = '0; m_hex = 1'b0;
    rst_n = 1'b0; load = 1'b0; hex_mode = 1'b0; value = '0; dp_in = '0;

    repeat (3) tick();
    rst_n = 1'b1;
    run(2 * RD * N);

    do_load(16'h1234, 1'b0, 4'b0000); run(2 * RD * N);
    do_load(16'hABCD, 1'b1, 4'b0000); run(RD * N);
    do_load(16'hABCD, 1'b0, 4'b0000); run(RD * N);
    do_load(16'h1234, 1'b0, 4'b0100); run(RD * N);

    // Load coinciding with a slot wrap.
    for (int i = 0; i < RD && (m_t % RD) != RD - 1; i++) tick();
    do_load(16'h5678, 1'b1, 4'b1001); run(RD * N);

    // Load held high: transparent capture.
    load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      value = 16'($urandom); hex_mode = 1'($urandom); dp_in = 4'($urandom);
      tick();
    end
    load = 1'b0;

    do_load(16'h0042, 1'b0, 4'b0000); run(RD * N);
    do_load(16'h0000, 1'b0, 4'b0000); run(RD * N);
    do_load(16'h0F00, 1'b1, 4'b0010); run(RD * N);

    // Reset pulsed mid-slot of digit 2.
    do_load(16'h9876, 1'b0, 4'b1111);
    for (int i = 0; i < RD * N && !(((m_t / RD) % N) == 2 && (m_t % RD) == 2); i++) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    run(RD * N);

    // Randomized traffic, with nibble masks that exercise leading zeros.
    for (int c = 0; c < 1500; c++) begin
      logic [15:0] mask;
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0F0F;
      endcase
      value    = 16'($urandom) & mask;
      hex_mode = 1'($urandom);
      dp_in    = 4'($urandom);
      load     = ($urandom_range(0, 7) == 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1; load = 1'b0;
    run(RD * N);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
